// File: rtl/guess_capture.sv
// Submit-button capture stage: synchronizes sw/btn, debounces btn, latches sw once per clean press.
// Capture strobe appears DEBOUNCE_CYCLES+2 edges after btn is first sampled; there is no backpressure.
module guess_capture #(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn,
    output logic [WIDTH-1:0] guess,
    output logic             guess_valid,
    output logic             busy,
    output logic [2:0]       press_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic             btn_meta_q;
    logic             btn_s_q;
    logic [WIDTH-1:0] sw_meta_q;
    logic [WIDTH-1:0] sw_s_q;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic             guess_valid_q, guess_valid_d;
    logic [2:0]       press_count_q, press_count_d;

    // Two-flop synchronizers; nothing downstream touches the raw inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
        end else begin
            btn_meta_q <= btn;
            btn_s_q    <= btn_meta_q;
            sw_meta_q  <= sw;
            sw_s_q     <= sw_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            guess_q       <= '0;
            guess_valid_q <= 1'b0;
            press_count_q <= 3'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            guess_q       <= guess_d;
            guess_valid_q <= guess_valid_d;
            press_count_q <= press_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        guess_d       = guess_q;
        guess_valid_d = 1'b0;
        press_count_d = press_count_q;

        unique case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = PRESS;
                    cnt_d   = 8'd1;
                end
            end
            // A low sample is checked first so a bounce on the final count still aborts.
            PRESS: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = HELD;
                    guess_d       = sw_s_q;
                    guess_valid_d = 1'b1;
                    press_count_d = press_count_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HELD: begin
                if (!btn_s_q) begin
                    state_d = RELEASE;
                    cnt_d   = 8'd1;
                end
            end
            RELEASE: begin
                if (btn_s_q) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign guess       = guess_q;
    assign guess_valid = guess_valid_q;
    assign press_count = press_count_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_guess_capture.sv
// Directed bench for guess_capture: per-cycle vector table for a clean press plus hand sequences.
module tb_guess_capture;

    logic       clk;
    logic       rst;
    logic [5:0] sw;
    logic       btn;
    logic [5:0] guess;
    logic       guess_valid;
    logic       busy;
    logic [2:0] press_count;

    int n_chk;
    int n_fail;
    int pulses;

    guess_capture #(.WIDTH(6), .DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .btn         (btn),
        .guess       (guess),
        .guess_valid (guess_valid),
        .busy        (busy),
        .press_count (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       btn;
        logic [5:0] sw;
        logic       gv;
        logic       busy;
        logic [5:0] guess;
        logic [2:0] pc;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: drive inputs, let one rising edge pass, return at the next negedge.
    task automatic step(input logic b, input logic [5:0] s);
        btn = b;
        sw  = s;
        @(posedge clk);
        @(negedge clk);
        if (guess_valid) pulses++;
    endtask

    task automatic do_reset();
        btn = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
    endtask

    task automatic press(input logic [5:0] s);
        for (int i = 0; i < 8; i++) step(1'b1, s);
        for (int i = 0; i < 8; i++) step(1'b0, s);
    endtask

    initial begin
        int busy_low;
        n_chk  = 0;
        n_fail = 0;
        pulses = 0;
        rst    = 1'b1;
        btn    = 1'b0;
        sw     = 6'h00;

        // Vector i drives btn before edge i; outputs are checked after edge i.
        vecs[0]  = '{1'b1, 6'h2A, 1'b0, 1'b0, 6'h00, 3'd0};
        vecs[1]  = '{1'b1, 6'h2A, 1'b0, 1'b0, 6'h00, 3'd0};
        vecs[2]  = '{1'b1, 6'h2A, 1'b0, 1'b1, 6'h00, 3'd0};
        vecs[3]  = '{1'b1, 6'h2A, 1'b0, 1'b1, 6'h00, 3'd0};
        vecs[4]  = '{1'b1, 6'h2A, 1'b0, 1'b1, 6'h00, 3'd0};
        vecs[5]  = '{1'b1, 6'h2A, 1'b1, 1'b1, 6'h2A, 3'd1};
        vecs[6]  = '{1'b1, 6'h2A, 1'b0, 1'b1, 6'h2A, 3'd1};
        vecs[7]  = '{1'b1, 6'h2A, 1'b0, 1'b1, 6'h2A, 3'd1};
        vecs[8]  = '{1'b0, 6'h2A, 1'b0, 1'b1, 6'h2A, 3'd1};
        vecs[9]  = '{1'b0, 6'h2A, 1'b0, 1'b1, 6'h2A, 3'd1};
        vecs[10] = '{1'b0, 6'h2A, 1'b0, 1'b1, 6'h2A, 3'd1};
        vecs[11] = '{1'b0, 6'h2A, 1'b0, 1'b1, 6'h2A, 3'd1};
        vecs[12] = '{1'b0, 6'h2A, 1'b0, 1'b1, 6'h2A, 3'd1};
        vecs[13] = '{1'b0, 6'h2A, 1'b0, 1'b0, 6'h2A, 3'd1};
        vecs[14] = '{1'b0, 6'h2A, 1'b0, 1'b0, 6'h2A, 3'd1};

        #1;
        chk("reset_guess", 32'(guess), 32'h0);
        chk("reset_gv", 32'(guess_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_pc", 32'(press_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Clean press, cycle by cycle
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].btn, vecs[i].sw);
            chk($sformatf("clean[%0d].gv", i), 32'(guess_valid), 32'(vecs[i].gv));
            chk($sformatf("clean[%0d].busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("clean[%0d].guess", i), 32'(guess), 32'(vecs[i].guess));
            chk($sformatf("clean[%0d].pc", i), 32'(press_count), 32'(vecs[i].pc));
        end

        // Bounce reject
        do_reset();
        for (int r = 0; r < 5; r++) begin
            step(1'b1, 6'h2A);
            step(1'b1, 6'h2A);
            step(1'b0, 6'h2A);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 6'h2A);
        chk("bounce_pulses", 32'(pulses), 32'd0);
        chk("bounce_guess", 32'(guess), 32'h0);
        chk("bounce_busy", 32'(busy), 32'h0);
        chk("bounce_pc", 32'(press_count), 32'h0);

        // Held button
        do_reset();
        busy_low = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 6'h07);
            if (i >= 2 && !busy) busy_low++;
        end
        chk("held_pulses", 32'(pulses), 32'd1);
        chk("held_busy_low", 32'(busy_low), 32'd0);
        chk("held_guess", 32'(guess), 32'h07);
        for (int i = 0; i < 8; i++) step(1'b0, 6'h07);
        chk("held_idle", 32'(busy), 32'h0);

        // Release bounce
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 6'h05);
        step(1'b0, 6'h05);
        step(1'b0, 6'h05);
        step(1'b1, 6'h05);
        for (int i = 0; i < 10; i++) step(1'b0, 6'h05);
        chk("relb_pulses", 32'(pulses), 32'd1);
        chk("relb_pc", 32'(press_count), 32'd1);
        chk("relb_guess", 32'(guess), 32'h05);
        chk("relb_busy", 32'(busy), 32'h0);

        // Two presses, then wrap after nine total
        do_reset();
        press(6'h11);
        chk("two_first_guess", 32'(guess), 32'h11);
        press(6'h3F);
        chk("two_second_guess", 32'(guess), 32'h3F);
        chk("two_pc", 32'(press_count), 32'd2);
        for (int i = 0; i < 7; i++) press(6'(i + 1));
        chk("wrap_pc", 32'(press_count), 32'd1);
        chk("wrap_pulses", 32'(pulses), 32'd9);
        chk("wrap_guess", 32'(guess), 32'h07);

        // Async reset mid-PRESS (cnt==2 after edge 3)
        do_reset();
        press(6'h15);
        for (int i = 0; i < 4; i++) step(1'b1, 6'h2A);
        chk("pre_arst_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_guess", 32'(guess), 32'h0);
        chk("arst_gv", 32'(guess_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_pc", 32'(press_count), 32'h0);
        #1 rst = 1'b0;
        pulses = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (guess_valid) pulses++;
            chk($sformatf("post_arst_gv[%0d]", e), 32'(guess_valid), 32'(e == 5));
        end
        chk("post_arst_guess", 32'(guess), 32'h2A);
        chk("post_arst_pc", 32'(press_count), 32'd1);
        step(1'b1, 6'h2A);
        chk("post_arst_gv_clear", 32'(guess_valid), 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 6'h2A);
        chk("post_arst_pulses", 32'(pulses), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
